// File: rtl/id_ex_reg_pkg.sv
// Shared pipeline definitions: RV32I opcodes, bubble field values and the
// ID/EX register layout used by the ID/EX stage and the EX hazard checker.
package id_ex_reg_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    localparam logic [4:0]  BUBBLE_REG  = 5'd0;
    localparam logic [31:0] BUBBLE_DATA = 32'd0;
    localparam logic [31:0] BUBBLE_PC   = 32'd0;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imme;
        logic        regwrite;
        logic        memtoreg;
        logic        memwrite;
    } id_ex_t;

    // addi x0,x0,0 with every side-effect control bit cleared
    function automatic id_ex_t bubble_fields(input logic [6:0] op);
        id_ex_t b;
        b.valid    = 1'b0;
        b.pc       = BUBBLE_PC;
        b.opcode   = op;
        b.funct3   = 3'd0;
        b.funct7   = 7'd0;
        b.rs1      = BUBBLE_REG;
        b.rs2      = BUBBLE_REG;
        b.rd       = BUBBLE_REG;
        b.rs1_data = BUBBLE_DATA;
        b.rs2_data = BUBBLE_DATA;
        b.imme     = BUBBLE_DATA;
        b.regwrite = 1'b0;
        b.memtoreg = 1'b0;
        b.memwrite = 1'b0;
        return b;
    endfunction

    // x0 is hardwired to zero, so a forward targeting it is never taken
    function automatic logic use_forward(input logic en, input logic [4:0] idx);
        return en && (idx != BUBBLE_REG);
    endfunction

endpackage

// File: rtl/id_ex_reg_sat_counter.sv
// Saturating up-counter; sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ONE = W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + ONE;
    end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with flush/stall handling, operand forwarding
// into EX and stall/flush performance counters.
module id_ex_reg
    import id_ex_reg_pkg::*;
#(
    parameter logic [6:0] OP_IMME_ARITHMETIC = OP_IMM,
    parameter int         CNT_W              = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ID_valid,
    input  logic [31:0]      ID_pc,
    input  logic [6:0]       ID_opcode,
    input  logic [2:0]       ID_funct3,
    input  logic [6:0]       ID_funct7,
    input  logic [4:0]       ID_rs1,
    input  logic [4:0]       ID_rs2,
    input  logic [4:0]       ID_rd,
    input  logic [31:0]      ID_rs1_data,
    input  logic [31:0]      ID_rs2_data,
    input  logic [31:0]      ID_imme,
    input  logic             ID_regwrite,
    input  logic             ID_memtoreg,
    input  logic             ID_memwrite,
    input  logic             EX_stall,
    input  logic             EX_flush,
    input  logic [31:0]      EX_hazard_rs1_data,
    input  logic [31:0]      EX_hazard_rs2_data,
    input  logic             EX_hazard_rs1_data_enable,
    input  logic             EX_hazard_rs2_data_enable,
    output logic             ID_EX_valid,
    output logic [31:0]      ID_EX_pc,
    output logic [6:0]       ID_EX_opcode,
    output logic [2:0]       ID_EX_funct3,
    output logic [6:0]       ID_EX_funct7,
    output logic [4:0]       ID_EX_rs1,
    output logic [4:0]       ID_EX_rs2,
    output logic [4:0]       ID_EX_rd,
    output logic [31:0]      ID_EX_rs1_data,
    output logic [31:0]      ID_EX_rs2_data,
    output logic [31:0]      ID_EX_imme,
    output logic             ID_EX_regwrite,
    output logic             ID_EX_memtoreg,
    output logic             ID_EX_memwrite,
    output logic [31:0]      EX_operand_a,
    output logic [31:0]      EX_operand_b,
    output logic             ID_EX_issue,
    output logic             IF_ID_hold,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    id_ex_t ex_p0;
    id_ex_t ex_p1;
    logic   fwd_rs1;
    logic   fwd_rs2;

    assign fwd_rs1 = use_forward(EX_hazard_rs1_data_enable, ex_p1.rs1);
    assign fwd_rs2 = use_forward(EX_hazard_rs2_data_enable, ex_p1.rs2);

    // ID -> EX boundary: flush beats stall; a stall keeps re-latching forwards
    always_comb begin
        ex_p0 = ex_p1;
        if (EX_flush || (!EX_stall && !ID_valid)) begin
            ex_p0 = bubble_fields(OP_IMME_ARITHMETIC);
        end else if (EX_stall) begin
            if (fwd_rs1) ex_p0.rs1_data = EX_hazard_rs1_data;
            if (fwd_rs2) ex_p0.rs2_data = EX_hazard_rs2_data;
        end else begin
            ex_p0.valid    = 1'b1;
            ex_p0.pc       = ID_pc;
            ex_p0.opcode   = ID_opcode;
            ex_p0.funct3   = ID_funct3;
            ex_p0.funct7   = ID_funct7;
            ex_p0.rs1      = ID_rs1;
            ex_p0.rs2      = ID_rs2;
            ex_p0.rd       = ID_rd;
            ex_p0.rs1_data = (ID_rs1 == BUBBLE_REG) ? BUBBLE_DATA : ID_rs1_data;
            ex_p0.rs2_data = (ID_rs2 == BUBBLE_REG) ? BUBBLE_DATA : ID_rs2_data;
            ex_p0.imme     = ID_imme;
            ex_p0.regwrite = ID_regwrite;
            ex_p0.memtoreg = ID_memtoreg;
            ex_p0.memwrite = ID_memwrite;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ex_p1 <= bubble_fields(OP_IMME_ARITHMETIC);
        else
            ex_p1 <= ex_p0;
    end

    assign ID_EX_valid    = ex_p1.valid;
    assign ID_EX_pc       = ex_p1.pc;
    assign ID_EX_opcode   = ex_p1.opcode;
    assign ID_EX_funct3   = ex_p1.funct3;
    assign ID_EX_funct7   = ex_p1.funct7;
    assign ID_EX_rs1      = ex_p1.rs1;
    assign ID_EX_rs2      = ex_p1.rs2;
    assign ID_EX_rd       = ex_p1.rd;
    assign ID_EX_rs1_data = ex_p1.rs1_data;
    assign ID_EX_rs2_data = ex_p1.rs2_data;
    assign ID_EX_imme     = ex_p1.imme;
    assign ID_EX_regwrite = ex_p1.regwrite;
    assign ID_EX_memtoreg = ex_p1.memtoreg;
    assign ID_EX_memwrite = ex_p1.memwrite;

    assign EX_operand_a = fwd_rs1 ? EX_hazard_rs1_data : ex_p1.rs1_data;
    assign EX_operand_b = fwd_rs2 ? EX_hazard_rs2_data : ex_p1.rs2_data;
    assign ID_EX_issue  = ex_p1.valid & ~EX_stall;
    assign IF_ID_hold   = EX_stall & ~EX_flush;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (EX_stall & ~EX_flush),
        .count (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (EX_flush),
        .count (flush_count)
    );

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed bench for id_ex_reg: behavioural model checked every cycle plus
// hand-computed literal expectations for the key scenarios.
module tb_id_ex_reg;

    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n;
    logic ID_valid;
    logic [31:0] ID_pc, ID_rs1_data, ID_rs2_data, ID_imme;
    logic [6:0] ID_opcode, ID_funct7;
    logic [2:0] ID_funct3;
    logic [4:0] ID_rs1, ID_rs2, ID_rd;
    logic ID_regwrite, ID_memtoreg, ID_memwrite;
    logic EX_stall, EX_flush;
    logic [31:0] EX_hazard_rs1_data, EX_hazard_rs2_data;
    logic EX_hazard_rs1_data_enable, EX_hazard_rs2_data_enable;
    logic ID_EX_valid, ID_EX_regwrite, ID_EX_memtoreg, ID_EX_memwrite;
    logic [31:0] ID_EX_pc, ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imme;
    logic [6:0] ID_EX_opcode, ID_EX_funct7;
    logic [2:0] ID_EX_funct3;
    logic [4:0] ID_EX_rs1, ID_EX_rs2, ID_EX_rd;
    logic [31:0] EX_operand_a, EX_operand_b;
    logic ID_EX_issue, IF_ID_hold;
    logic [CW-1:0] stall_count, flush_count;

    always #5 clk = ~clk;

    id_ex_reg #(.OP_IMME_ARITHMETIC(7'b0010011), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .ID_valid(ID_valid), .ID_pc(ID_pc),
        .ID_opcode(ID_opcode), .ID_funct3(ID_funct3), .ID_funct7(ID_funct7),
        .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_rd(ID_rd),
        .ID_rs1_data(ID_rs1_data), .ID_rs2_data(ID_rs2_data), .ID_imme(ID_imme),
        .ID_regwrite(ID_regwrite), .ID_memtoreg(ID_memtoreg), .ID_memwrite(ID_memwrite),
        .EX_stall(EX_stall), .EX_flush(EX_flush),
        .EX_hazard_rs1_data(EX_hazard_rs1_data), .EX_hazard_rs2_data(EX_hazard_rs2_data),
        .EX_hazard_rs1_data_enable(EX_hazard_rs1_data_enable),
        .EX_hazard_rs2_data_enable(EX_hazard_rs2_data_enable),
        .ID_EX_valid(ID_EX_valid), .ID_EX_pc(ID_EX_pc), .ID_EX_opcode(ID_EX_opcode),
        .ID_EX_funct3(ID_EX_funct3), .ID_EX_funct7(ID_EX_funct7),
        .ID_EX_rs1(ID_EX_rs1), .ID_EX_rs2(ID_EX_rs2), .ID_EX_rd(ID_EX_rd),
        .ID_EX_rs1_data(ID_EX_rs1_data), .ID_EX_rs2_data(ID_EX_rs2_data),
        .ID_EX_imme(ID_EX_imme), .ID_EX_regwrite(ID_EX_regwrite),
        .ID_EX_memtoreg(ID_EX_memtoreg), .ID_EX_memwrite(ID_EX_memwrite),
        .EX_operand_a(EX_operand_a), .EX_operand_b(EX_operand_b),
        .ID_EX_issue(ID_EX_issue), .IF_ID_hold(IF_ID_hold),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    int nvec = 0;
    int nerr = 0;
    bit run  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: what the EX stage should hold, from the stage rules
    typedef struct {
        bit vld; int unsigned pc, op, f3, f7, rs1, rs2, rd, d1, d2, imm;
        bit rw, mtr, mw;
    } mdl_t;

    mdl_t m;
    int   m_sc, m_fc;

    function automatic mdl_t nop_instr();
        mdl_t b = '{default: 0};
        b.op = 'h13;
        return b;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m <= nop_instr(); m_sc <= 0; m_fc <= 0;
        end else begin
            if (EX_flush || (!EX_stall && !ID_valid)) begin
                m <= nop_instr();
            end else if (EX_stall) begin
                if (EX_hazard_rs1_data_enable && m.rs1 != 0) m.d1 <= EX_hazard_rs1_data;
                if (EX_hazard_rs2_data_enable && m.rs2 != 0) m.d2 <= EX_hazard_rs2_data;
            end else begin
                m <= '{1, ID_pc, ID_opcode, ID_funct3, ID_funct7, ID_rs1, ID_rs2, ID_rd,
                       (ID_rs1 == 0) ? 0 : ID_rs1_data, (ID_rs2 == 0) ? 0 : ID_rs2_data,
                       ID_imme, ID_regwrite, ID_memtoreg, ID_memwrite};
            end
            if (EX_flush) m_fc <= (m_fc < CMAX) ? m_fc + 1 : CMAX;
            else if (EX_stall) m_sc <= (m_sc < CMAX) ? m_sc + 1 : CMAX;
        end
    end

    always @(negedge clk) begin
        if (run) begin
            chk("valid", ID_EX_valid, m.vld);
            chk("pc", ID_EX_pc, m.pc);
            chk("opcode", ID_EX_opcode, m.op);
            chk("funct3", ID_EX_funct3, m.f3);
            chk("funct7", ID_EX_funct7, m.f7);
            chk("rs1", ID_EX_rs1, m.rs1);
            chk("rs2", ID_EX_rs2, m.rs2);
            chk("rd", ID_EX_rd, m.rd);
            chk("rs1_data", ID_EX_rs1_data, m.d1);
            chk("rs2_data", ID_EX_rs2_data, m.d2);
            chk("imme", ID_EX_imme, m.imm);
            chk("ctrl", {ID_EX_regwrite, ID_EX_memtoreg, ID_EX_memwrite}, {m.rw, m.mtr, m.mw});
            chk("operand_a", EX_operand_a,
                (EX_hazard_rs1_data_enable && m.rs1 != 0) ? EX_hazard_rs1_data : m.d1);
            chk("operand_b", EX_operand_b,
                (EX_hazard_rs2_data_enable && m.rs2 != 0) ? EX_hazard_rs2_data : m.d2);
            chk("issue", ID_EX_issue, m.vld && !EX_stall);
            chk("hold", IF_ID_hold, EX_stall && !EX_flush);
            chk("stall_count", stall_count, m_sc);
            chk("flush_count", flush_count, m_fc);
        end
    end

    task automatic put(input logic [31:0] pc, input logic [6:0] op, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] d1,
                       input logic [31:0] d2, input logic [31:0] imm, input logic [2:0] ctl);
        ID_valid = 1'b1; ID_pc = pc; ID_opcode = op; ID_funct3 = pc[4:2]; ID_funct7 = {pc[8:5], 3'b0};
        ID_rs1 = rs1; ID_rs2 = rs2; ID_rd = rd; ID_rs1_data = d1; ID_rs2_data = d2;
        ID_imme = imm; {ID_regwrite, ID_memtoreg, ID_memwrite} = ctl;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic at_neg();
        @(negedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; ID_valid = 0; EX_stall = 0; EX_flush = 0;
        EX_hazard_rs1_data = 0; EX_hazard_rs2_data = 0;
        EX_hazard_rs1_data_enable = 0; EX_hazard_rs2_data_enable = 0;
        put(0, 0, 0, 0, 0, 0, 0, 0, 3'b000); ID_valid = 0;
        repeat (2) tick();
        run = 1'b1;
        at_neg();
        chk("rst_valid", ID_EX_valid, 0);
        chk("rst_opcode", ID_EX_opcode, 7'b0010011);
        chk("rst_issue", ID_EX_issue, 0);
        chk("rst_counts", {stall_count, flush_count}, 0);
        rst_n = 1'b1;
        tick();

        // pass-through: add x5, x3, x0
        put(32'h100, 7'b0110011, 5'd3, 5'd0, 5'd5, 32'h1234, 32'h5555, 0, 3'b100);
        tick();
        put(32'h104, 7'b0110011, 5'd4, 5'd6, 5'd7, 32'h1111, 32'h2222, 32'h8, 3'b100);
        at_neg();
        chk("pt_rd", ID_EX_rd, 5);
        chk("pt_rs1_data", ID_EX_rs1_data, 32'h1234);
        chk("pt_rs2_data_x0", ID_EX_rs2_data, 0);
        chk("pt_issue", ID_EX_issue, 1);

        // load-use stall with forwarding on rs1 and an x0-targeted forward on rs2
        EX_stall = 1; EX_hazard_rs1_data = 32'hAAAA; EX_hazard_rs1_data_enable = 1;
        EX_hazard_rs2_data = 32'hFFFF; EX_hazard_rs2_data_enable = 1;
        #1;
        chk("st_hold", IF_ID_hold, 1);
        chk("st_issue", ID_EX_issue, 0);
        chk("st_operand_a", EX_operand_a, 32'hAAAA);
        chk("st_operand_b_x0", EX_operand_b, 0);
        tick();
        EX_stall = 0; EX_hazard_rs1_data_enable = 0; EX_hazard_rs2_data_enable = 0;
        at_neg();
        chk("st_rd_held", ID_EX_rd, 5);
        chk("st_pc_held", ID_EX_pc, 32'h100);
        chk("st_rs1_latched", ID_EX_rs1_data, 32'hAAAA);
        chk("st_rs2_not_latched", ID_EX_rs2_data, 0);
        chk("st_count", stall_count, 1);
        tick();
        at_neg();
        chk("adv_rd", ID_EX_rd, 7);
        chk("adv_rs2_data", ID_EX_rs2_data, 32'h2222);

        // stall and flush together: flush wins
        EX_stall = 1; EX_flush = 1;
        #1;
        chk("sf_hold", IF_ID_hold, 0);
        tick();
        EX_stall = 0; EX_flush = 0;
        at_neg();
        chk("sf_valid", ID_EX_valid, 0);
        chk("sf_opcode", ID_EX_opcode, 7'b0010011);
        chk("sf_rd", ID_EX_rd, 0);
        chk("sf_flush_count", flush_count, 1);
        chk("sf_stall_count", stall_count, 1);
        tick();

        // three stall cycles, the last latch of each operand wins
        EX_stall = 1; EX_hazard_rs1_data = 32'h11; EX_hazard_rs1_data_enable = 1;
        tick();
        EX_hazard_rs1_data_enable = 0; EX_hazard_rs2_data = 32'h22; EX_hazard_rs2_data_enable = 1;
        tick();
        EX_hazard_rs1_data = 32'h33; EX_hazard_rs1_data_enable = 1; EX_hazard_rs2_data_enable = 0;
        tick();
        EX_stall = 0; EX_hazard_rs1_data_enable = 0;
        at_neg();
        chk("ms_rs1_data", ID_EX_rs1_data, 32'h33);
        chk("ms_rs2_data", ID_EX_rs2_data, 32'h22);
        chk("ms_rd", ID_EX_rd, 7);
        chk("ms_stall_count", stall_count, 4);

        // invalid ID instruction loads a bubble
        ID_valid = 0;
        tick();
        at_neg();
        chk("inv_valid", ID_EX_valid, 0);
        chk("inv_regwrite", ID_EX_regwrite, 0);
        chk("inv_opcode", ID_EX_opcode, 7'b0010011);

        // asynchronous reset in the middle of a stall
        ID_valid = 1;
        tick();
        EX_stall = 1;
        #2 rst_n = 0;
        #1;
        chk("ar_valid", ID_EX_valid, 0);
        chk("ar_opcode", ID_EX_opcode, 7'b0010011);
        chk("ar_regwrite", ID_EX_regwrite, 0);
        chk("ar_counts", {stall_count, flush_count}, 0);
        chk("ar_issue", ID_EX_issue, 0);
        #1 rst_n = 1; EX_stall = 0;
        tick();
        at_neg();
        chk("ar_resume_valid", ID_EX_valid, 1);
        chk("ar_resume_rd", ID_EX_rd, 7);

        // counter saturation
        EX_stall = 1;
        repeat (20) tick();
        EX_stall = 0;
        at_neg();
        chk("sat_stall", stall_count, 4'hF);
        EX_flush = 1;
        repeat (20) tick();
        EX_flush = 0;
        at_neg();
        chk("sat_flush", flush_count, 4'hF);
        chk("sat_stall_kept", stall_count, 4'hF);

        // mixed traffic, checked by the model alone
        for (int i = 0; i < 24; i++) begin
            put(32'h200 + 4 * i, (i % 3 == 0) ? 7'b0000011 : 7'b0110011, 5'(i % 4),
                5'((i + 1) % 3), 5'(i), $urandom, $urandom, $urandom, 3'(i));
            ID_valid = (i % 5) != 4;
            EX_stall = (i % 4) == 1;
            EX_flush = (i % 7) == 3;
            EX_hazard_rs1_data = $urandom; EX_hazard_rs1_data_enable = i[0];
            EX_hazard_rs2_data = $urandom; EX_hazard_rs2_data_enable = i[1];
            tick();
        end
        EX_stall = 0; EX_flush = 0;
        at_neg();
        run = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: ID_EX_reg

Interface
REQ-001 SHALL have parameter OP_IMME_ARITHMETIC, default 7'b0010011, opcode loaded on a bubble (addi x0,x0,0 form).
REQ-002 SHALL have parameter CNT_W, default 16, width of the stall and flush counters.
REQ-003 SHALL use one clock, clk; reset rst_n is asynchronous, active-low.
REQ-004 Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- ID_valid  in  1  ID holds a real instruction
- ID_pc  in  32  instruction PC
- ID_opcode/ID_funct3/ID_funct7  in  7/3/7  decoded fields
- ID_rs1/ID_rs2/ID_rd  in  5 each  register indices
- ID_rs1_data/ID_rs2_data  in  32 each  register-file read data
- ID_imme  in  32  sign-extended immediate
- ID_regwrite/ID_memtoreg/ID_memwrite  in  1 each  control bits
- EX_stall  in  1  load-use stall from the EX hazard checker
- EX_flush  in  1  taken branch/jump resolved in EX
- EX_hazard_rs1_data/EX_hazard_rs2_data  in  32 each  forwarded data
- EX_hazard_rs1_data_enable/EX_hazard_rs2_data_enable  in  1 each  forward valid
- ID_EX_valid, ID_EX_pc, ID_EX_opcode, ID_EX_funct3, ID_EX_funct7, ID_EX_rs1, ID_EX_rs2, ID_EX_rd, ID_EX_imme, ID_EX_regwrite, ID_EX_memtoreg, ID_EX_memwrite  out  as inputs  registered fields
- EX_operand_a/EX_operand_b  out  32 each  resolved rs1/rs2 operands for the ALU
- ID_EX_issue  out  1  instruction in EX advances to EX_MEM this cycle
- IF_ID_hold  out  1  freeze PC and IF/ID register
- stall_count/flush_count  out  CNT_W each  performance counters

Function
REQ-005 Normal update (EX_flush=0, EX_stall=0): SHALL capture all ID_* fields on the rising edge of clk, with 1-cycle latency.
REQ-006 SHALL capture rs data as 0 when the matching index is 0.
REQ-007 Flush: SHALL load a bubble: valid=0, regwrite=0, memtoreg=0, memwrite=0, opcode=OP_IMME_ARITHMETIC, rd/rs1/rs2=0, data/imme=0; pc is don't-care, loaded 0.
REQ-008 Flush SHALL take priority over stall when both are asserted.
REQ-009 Stall only: SHALL hold all fields except rs1/rs2 data.
REQ-010 During a stall, SHALL overwrite the held rsN data with EX_hazard_rsN_data when its enable is 1 and ID_EX_rsN!=0, so that a producer retiring during the stall is not lost.
REQ-011 EX_operand_a SHALL be EX_hazard_rs1_data when enable=1 and ID_EX_rs1!=0, otherwise ID_EX_rs1_data; EX_operand_b SHALL be formed the same way from rs2. This path is combinational.
REQ-012 ID_EX_issue SHALL equal ID_EX_valid & ~EX_stall; EX_MEM inserts a bubble when it is 0.
REQ-013 IF_ID_hold SHALL equal EX_stall & ~EX_flush (combinational).
REQ-014 stall_count SHALL increment on each cycle with EX_stall=1 and EX_flush=0; flush_count SHALL increment on each cycle with EX_flush=1.
REQ-015 Both counters SHALL saturate at all-ones and not wrap.
REQ-016 Consecutive stall cycles SHALL hold indefinitely; each cycle re-evaluates REQ-010, and the last latch wins.
REQ-017 ID_valid=0 with no stall or flush SHALL load a bubble identical to REQ-007.

Reset
REQ-018 rst_n=0 SHALL asynchronously force the REQ-007 bubble contents and zero both counters.
REQ-019 ID_EX_issue SHALL be 0 while rst_n=0 or after reset.
REQ-020 Reset deassertion mid-stall SHALL resume REQ-005 behaviour on the first clock edge.

Structure
REQ-021 Opcode constants (OP_*) and the bubble field values SHALL live in the shared pipeline package and be used by ID_EX_reg and the EX hazard checker.
REQ-022 The saturating counter SHALL be one sub-module, sat_counter (parameter W; inputs clk, rst_n, inc; output count), instantiated twice.

Verification
REQ-023 Reset: rst_n=0 mid-run -> ID_EX_valid=0, opcode=7'b0010011, regwrite=0, counters=0 immediately, without waiting for a clock edge.
REQ-024 Pass-through: ID_rd=5, ID_rs1_data=32'h1234, ID_valid=1 -> next cycle ID_EX_rd=5, ID_EX_rs1_data=32'h1234, ID_EX_issue=1.
REQ-025 Load-use stall: EX_stall=1 for 1 cycle, EX_hazard_rs1_data=32'hAAAA with enable=1 and ID_EX_rs1=3 -> fields held, ID_EX_rs1_data=32'hAAAA, IF_ID_hold=1, ID_EX_issue=0, stall_count=1.
REQ-026 x0 guard: ID_EX_rs2=0, enable=1, EX_hazard_rs2_data=32'hFFFF -> EX_operand_b=0, no latch during stall.
REQ-027 Stall+flush same cycle -> bubble loaded, IF_ID_hold=0, flush_count+1, stall_count unchanged.
REQ-028 Saturation: CNT_W=4 with 20 stall cycles -> stall_count=4'hF.
